// File: rtl/dmem_pkg.sv
// Shared types and address helpers for the banked, big-endian data memory.
package dmem_pkg;

    typedef enum logic {
        SZ_BYTE = 1'b0,
        SZ_WORD = 1'b1
    } size_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SPLIT = 2'd1,
        CLEAR = 2'd2
    } state_e;

    function automatic int unsigned lane_of(input logic [31:0] addr, input int unsigned nbytes);
        return addr % nbytes;
    endfunction

    function automatic int unsigned row_of(input logic [31:0] addr, input int unsigned nbytes);
        return addr / nbytes;
    endfunction

endpackage

// File: rtl/dmem_bank.sv
// One byte lane of the data memory: single port, synchronous write and registered read.
module dmem_bank #(
    parameter int ROWS  = 512,
    parameter int ROW_W = 9
) (
    input  logic             clk,
    input  logic             en,
    input  logic             we,
    input  logic [ROW_W-1:0] row,
    input  logic [7:0]       wdata,
    output logic [7:0]       rdata
);

    logic [7:0] mem [ROWS];

    // rdata holds between reads so a split word can be assembled from two cycles
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[row] <= wdata;
            end else begin
                rdata <= mem[row];
            end
        end
    end

endmodule

// File: rtl/data_mem_banked.sv
// Byte-addressed big-endian data memory built from NBYTES byte-lane banks; misaligned words take two cycles.
// Optional build macro DMEM_CLEAR_EN: reset sweeps every row to zero before accepting requests.
module data_mem_banked
    import dmem_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int DEPTH_BYTES = 1024,
    parameter int ADDR_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  size_e             size,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              ready,
    output logic              rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              err
);

    localparam int NBYTES = DATA_W / 8;
    localparam int ROWS   = DEPTH_BYTES / NBYTES;
    localparam int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int LANE_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    function automatic logic [7:0] get_byte(input logic [DATA_W-1:0] w, input int k);
        return w[(NBYTES-1-k)*8 +: 8];
    endfunction

    state_e state, state_nxt;

    logic              accept;
    logic              acc_ok;
    logic              acc_split;
    logic [LANE_W-1:0] acc_lane;
    logic [ROW_W-1:0]  acc_row;
    logic [ADDR_W:0]   last_byte;
    logic              in_range;

    logic              vld_p1;
    logic              err_p1;
    logic [LANE_W-1:0] rd_lane_p1;
    size_e             rd_size_p1;
    logic [DATA_W-1:0] rd_word;

    logic [ROW_W-1:0]  sp_row_p1;
    logic [LANE_W-1:0] sp_lane_p1;
    logic              sp_we_p1;
    logic [DATA_W-1:0] sp_wdata_p1;

`ifdef DMEM_CLEAR_EN
    logic [ROW_W-1:0]  clr_row;
`endif

    logic              bank_en  [NBYTES];
    logic              bank_we  [NBYTES];
    logic [ROW_W-1:0]  bank_row [NBYTES];
    logic [7:0]        bank_wd  [NBYTES];
    logic [7:0]        bank_rd  [NBYTES];

    // Request decode: every byte of the access must lie below DEPTH_BYTES, no wrap
    assign acc_lane  = LANE_W'(lane_of(32'(addr), NBYTES));
    assign acc_row   = ROW_W'(row_of(32'(addr), NBYTES));
    assign last_byte = {1'b0, addr} + ((size == SZ_WORD) ? (ADDR_W+1)'(NBYTES-1) : '0);
    assign in_range  = last_byte < (ADDR_W+1)'(DEPTH_BYTES);
    assign accept    = req && ready && !rst;
    assign acc_ok    = accept && in_range;
    assign acc_split = acc_ok && (size == SZ_WORD) && (acc_lane != '0);

    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (acc_split) state_nxt = SPLIT;
            end
            SPLIT: state_nxt = IDLE;
`ifdef DMEM_CLEAR_EN
            CLEAR: if (clr_row == ROW_W'(ROWS-1)) state_nxt = IDLE;
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
`ifdef DMEM_CLEAR_EN
            state   <= CLEAR;
            clr_row <= '0;
`else
            state   <= IDLE;
`endif
            vld_p1  <= 1'b0;
            err_p1  <= 1'b0;
        end else begin
            state  <= state_nxt;
            vld_p1 <= (accept && !we && !acc_split) || ((state == SPLIT) && !sp_we_p1);
            err_p1 <= accept && !in_range;
`ifdef DMEM_CLEAR_EN
            if (state == CLEAR) clr_row <= clr_row + ROW_W'(1);
`endif
        end
    end

    // Accept stage: capture read steering and the second half of a split access
    always_ff @(posedge clk) begin
        if (accept) begin
            rd_lane_p1 <= acc_lane;
            rd_size_p1 <= size;
        end
        if (acc_split) begin
            sp_row_p1   <= acc_row + ROW_W'(1);
            sp_lane_p1  <= acc_lane;
            sp_we_p1    <= we;
            sp_wdata_p1 <= wdata;
        end
    end

    // Lane steering: word byte k goes to lane (o+k) mod NBYTES, spilling into row r+1
    always_comb begin
        for (int j = 0; j < NBYTES; j++) begin
            bank_en[j]  = 1'b0;
            bank_we[j]  = 1'b0;
            bank_row[j] = '0;
            bank_wd[j]  = '0;
        end
`ifdef DMEM_CLEAR_EN
        if (state == CLEAR && !rst) begin
            for (int j = 0; j < NBYTES; j++) begin
                bank_en[j]  = 1'b1;
                bank_we[j]  = 1'b1;
                bank_row[j] = clr_row;
            end
        end else
`endif
        if (state == SPLIT && !rst) begin
            for (int j = 0; j < NBYTES; j++) begin
                if (j < int'(sp_lane_p1)) begin
                    bank_en[j]  = 1'b1;
                    bank_we[j]  = sp_we_p1;
                    bank_row[j] = sp_row_p1;
                    bank_wd[j]  = get_byte(sp_wdata_p1, NBYTES - int'(sp_lane_p1) + j);
                end
            end
        end else if (acc_ok) begin
            for (int j = 0; j < NBYTES; j++) begin
                if (size == SZ_BYTE) begin
                    if (j == int'(acc_lane)) begin
                        bank_en[j]  = 1'b1;
                        bank_we[j]  = we;
                        bank_row[j] = acc_row;
                        bank_wd[j]  = wdata[7:0];
                    end
                end else if (j >= int'(acc_lane)) begin
                    bank_en[j]  = 1'b1;
                    bank_we[j]  = we;
                    bank_row[j] = acc_row;
                    bank_wd[j]  = get_byte(wdata, j - int'(acc_lane));
                end
            end
        end
    end

    for (genvar g = 0; g < NBYTES; g++) begin : g_lane
        dmem_bank #(
            .ROWS  (ROWS),
            .ROW_W (ROW_W)
        ) u_bank (
            .clk   (clk),
            .en    (bank_en[g]),
            .we    (bank_we[g]),
            .row   (bank_row[g]),
            .wdata (bank_wd[g]),
            .rdata (bank_rd[g])
        );
    end

    // Response stage: reassemble big-endian word from the lane outputs
    always_comb begin
        rd_word = '0;
        if (rd_size_p1 == SZ_BYTE) begin
            rd_word[7:0] = bank_rd[rd_lane_p1];
        end else begin
            for (int k = 0; k < NBYTES; k++) begin
                rd_word[(NBYTES-1-k)*8 +: 8] = bank_rd[LANE_W'((int'(rd_lane_p1) + k) % NBYTES)];
            end
        end
        rdata = (vld_p1 && !err_p1) ? rd_word : '0;
    end

    assign rvalid = vld_p1;
    assign err    = err_p1;

endmodule
